// File: rtl/npu_bias_buffer.sv
// Bias row store with a single-entry registered read port.
// Lane words are loaded one per cycle; reads return a full row.
module npu_bias_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CH       = 32,
  parameter int DEPTH      = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [LW-1:0]              wr_lane,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AW-1:0]              req_addr,
  input  logic                       bias_bypass,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [N_CH*DATA_WIDTH-1:0] rsp_data,
  output logic                       addr_err
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [LW:0] NCH_L   = (LW+1)'(N_CH);

  logic [DATA_WIDTH-1:0]      r_mem [DEPTH][N_CH];
  logic                       r_rsp_valid;
  logic [N_CH*DATA_WIDTH-1:0] r_rsp_data;
  logic                       r_addr_err;

  logic                       w_accept;
  logic                       w_wr_ok;
  logic                       w_rd_ok;
  logic                       w_err_set;
  logic [N_CH*DATA_WIDTH-1:0] w_rd_row;

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;
  assign w_wr_ok   = ({1'b0, wr_addr} < DEPTH_L)
                  && ({1'b0, wr_lane} < NCH_L);
  assign w_rd_ok   = {1'b0, req_addr} < DEPTH_L;
  assign w_err_set = (wr_en && !w_wr_ok)
                  || (w_accept && !bias_bypass && !w_rd_ok);

  // Bypass and out-of-range reads both yield an all-zero row.
  always_comb begin
    w_rd_row = '0;
    if (!bias_bypass && w_rd_ok) begin
      for (int j = 0; j < N_CH; j++) begin
        w_rd_row[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[req_addr][j];
      end
    end
  end

  // Read samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int j = 0; j < N_CH; j++) begin
          r_mem[r][j] <= '0;
        end
      end
    end else if (wr_en && w_wr_ok) begin
      r_mem[wr_addr][wr_lane] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_rd_row;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_err_set) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_npu_bias_buffer.sv
// Directed bench for npu_bias_buffer: an 8-row instance
// plus a 6-row instance for out-of-range handling.
module tb_npu_bias_buffer;

  localparam int DW = 16;
  localparam int NC = 32;
  localparam int RW = NC * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en, req_valid, bias_bypass, rsp_ready;
  logic [2:0]    wr_addr, req_addr;
  logic [4:0]    wr_lane;
  logic [DW-1:0] wr_data;
  logic          req_ready, rsp_valid, addr_err;
  logic [RW-1:0] rsp_data;

  logic          wr_en6, req_valid6, bias6, rsp_ready6;
  logic [2:0]    wr_addr6, req_addr6;
  logic [4:0]    wr_lane6;
  logic [DW-1:0] wr_data6;
  logic          req_ready6, rsp_valid6, addr_err6;
  logic [RW-1:0] rsp_data6;

  npu_bias_buffer #(.DATA_WIDTH(DW), .N_CH(NC), .DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_lane(wr_lane), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .bias_bypass(bias_bypass),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .addr_err(addr_err)
  );

  npu_bias_buffer #(.DATA_WIDTH(DW), .N_CH(NC), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en6), .wr_addr(wr_addr6),
    .wr_lane(wr_lane6), .wr_data(wr_data6),
    .req_valid(req_valid6), .req_ready(req_ready6),
    .req_addr(req_addr6), .bias_bypass(bias6),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready6),
    .rsp_data(rsp_data6), .addr_err(addr_err6)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [RW-1:0] obs,
                     input logic [RW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] row_val(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < NC; j++) begin
      v[j*DW +: DW] = 16'(r * 256 + j);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [RW-1:0] exp_r2;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wr_en = 0; wr_addr = 0; wr_lane = 0; wr_data = 0;
    req_valid = 0; req_addr = 0; bias_bypass = 0; rsp_ready = 0;
    wr_en6 = 0; wr_addr6 = 0; wr_lane6 = 0; wr_data6 = 0;
    req_valid6 = 0; req_addr6 = 0; bias6 = 0; rsp_ready6 = 0;

    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", addr_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load rows 0..7
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < NC; j++) begin
        wr_en = 1; wr_addr = 3'(r); wr_lane = 5'(j);
        wr_data = 16'(r * 256 + j);
        tick();
      end
    end
    wr_en = 0;

    // Single read of row 3
    req_valid = 1; req_addr = 3; rsp_ready = 1;
    chk("rd3_ready", req_ready, 1);
    tick();
    req_valid = 0;
    chk("rd3_valid", rsp_valid, 1);
    chk("rd3_lane5", rsp_data[5*DW +: DW], 16'h0305);
    chk("rd3_lane31", rsp_data[31*DW +: DW], 16'h031F);
    chk("rd3_row", rsp_data, row_val(3));
    tick();
    chk("rd3_drain", rsp_valid, 0);

    // Stream 0,1,2 with a stall on the row-1 response
    req_valid = 1; req_addr = 0; rsp_ready = 1;
    tick();
    chk("st_r0", rsp_data, row_val(0));
    req_addr = 1;
    tick();
    chk("st_r1", rsp_data, row_val(1));
    rsp_ready = 0; req_addr = 2;
    #1 chk("st_stall_rdy", req_ready, 0);
    tick();
    chk("st_hold_v", rsp_valid, 1);
    chk("st_hold_d", rsp_data, row_val(1));
    tick();
    chk("st_hold_d2", rsp_data, row_val(1));
    rsp_ready = 1;
    #1 chk("st_rel_rdy", req_ready, 1);
    tick();
    req_valid = 0;
    chk("st_r2", rsp_data, row_val(2));
    tick();
    chk("st_drain", rsp_valid, 0);

    // Same-cycle write and read of row 2
    wr_en = 1; wr_addr = 2; wr_lane = 0; wr_data = 16'hBEEF;
    req_valid = 1; req_addr = 2;
    tick();
    wr_en = 0; req_valid = 0; rsp_ready = 0;
    chk("rbw_lane0", rsp_data[0 +: DW], 16'h0200);
    // Later write must not touch the held response
    wr_en = 1; wr_addr = 2; wr_lane = 1; wr_data = 16'h1234;
    tick();
    wr_en = 0;
    chk("hold_wr_v", rsp_valid, 1);
    chk("hold_wr_d", rsp_data, row_val(2));
    rsp_ready = 1; req_valid = 1; req_addr = 2;
    tick();
    req_valid = 0;
    exp_r2 = row_val(2);
    exp_r2[0 +: DW] = 16'hBEEF;
    exp_r2[DW +: DW] = 16'h1234;
    chk("b2b_valid", rsp_valid, 1);
    chk("b2b_row2", rsp_data, exp_r2);
    tick();
    chk("b2b_drain", rsp_valid, 0);

    // Bypass on a valid row
    req_valid = 1; req_addr = 5; bias_bypass = 1;
    tick();
    req_valid = 0; bias_bypass = 0;
    chk("byp_valid", rsp_valid, 1);
    chk("byp_data", rsp_data, 0);
    chk("byp_err", addr_err, 0);
    tick();

    // Out-of-range read on the 6-row instance
    req_valid6 = 1; req_addr6 = 7; bias6 = 0; rsp_ready6 = 1;
    tick();
    req_valid6 = 0;
    chk("oor_valid", rsp_valid6, 1);
    chk("oor_data", rsp_data6, 0);
    chk("oor_err", addr_err6, 1);
    tick();
    tick();
    chk("oor_sticky", addr_err6, 1);
    chk("oor_drain", rsp_valid6, 0);

    // Asynchronous reset during a stalled response
    req_valid = 1; req_addr = 3; rsp_ready = 0;
    tick();
    req_valid = 0;
    chk("ar_pre_v", rsp_valid, 1);
    chk("ar_pre_d", rsp_data, row_val(3));
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", rsp_valid, 0);
    chk("ar_data", rsp_data, 0);
    chk("ar_err6", addr_err6, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1;
    tick();
    chk("ar_post_v", rsp_valid, 0);
    req_valid = 1; req_addr = 3;
    tick();
    req_valid = 0;
    chk("ar_rd3_v", rsp_valid, 1);
    chk("ar_rd3_d", rsp_data, 0);
    tick();

    // Out-of-range bypass read keeps addr_err clear
    req_valid6 = 1; req_addr6 = 7; bias6 = 1; rsp_ready6 = 1;
    tick();
    req_valid6 = 0; bias6 = 0;
    chk("oorb_valid", rsp_valid6, 1);
    chk("oorb_data", rsp_data6, 0);
    chk("oorb_err", addr_err6, 0);
    tick();
    chk("oorb_err2", addr_err6, 0);

    // Out-of-range write sets addr_err
    wr_en6 = 1; wr_addr6 = 6; wr_lane6 = 0; wr_data6 = 16'hAAAA;
    tick();
    wr_en6 = 0;
    chk("oorw_err", addr_err6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_bias_buffer.md
NPU_BIAS_BUFFER -- requirements
Module: npu_bias_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one bias lane word.
REQ-002 SHALL have parameter N_CH, default 32: number of bias lanes delivered per read.
REQ-003 SHALL have parameter DEPTH, default 8: number of bias rows. Legal range 2..256; need not be a power of 2.
REQ-004 SHALL derive localparams AW = clog2(DEPTH) and LW = clog2(N_CH).
REQ-005 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-006 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  load one lane word this cycle.
- wr_addr  in  AW  row to load.
- wr_lane  in  LW  lane to load.
- wr_data  in  DATA_WIDTH  bias value.
- req_valid  in  1  read request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_addr  in  AW  row to read.
- bias_bypass  in  1  return all-zero bias for this request.
- rsp_valid  out  1  rsp_data holds a response.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  N_CH*DATA_WIDTH  lane j at bits [DATA_WIDTH*j +: DATA_WIDTH].
- addr_err  out  1  sticky out-of-range flag.

Function
REQ-007 SHALL hold a DEPTH x N_CH x DATA_WIDTH register array, writable one lane word per cycle.
REQ-008 SHALL write wr_data into row wr_addr, lane wr_lane, on a clk edge when wr_en=1, wr_addr<DEPTH and wr_lane<N_CH.
REQ-009 SHALL drop the write and set addr_err when wr_en=1 and (wr_addr>=DEPTH or wr_lane>=N_CH).
REQ-010 SHALL drive req_ready = !rsp_valid || rsp_ready, combinationally: a single-entry output register with full-throughput pass-through.
REQ-011 SHALL define accept = req_valid && req_ready. On accept, rsp_data SHALL load on the same edge and rsp_valid SHALL be 1 the next cycle. Latency is exactly 1 cycle.
REQ-012 SHALL load all-zero rsp_data on accept when bias_bypass=1. This applies regardless of req_addr, and addr_err SHALL NOT be set.
REQ-013 SHALL load all-zero rsp_data and set addr_err on accept when bias_bypass=0 and req_addr>=DEPTH.
REQ-014 SHALL clear rsp_valid on an edge where rsp_valid && rsp_ready && !accept.
REQ-015 SHALL keep rsp_valid=1 and load new data on an edge where rsp_valid && rsp_ready && accept (back-to-back).
REQ-016 SHALL hold rsp_data and rsp_valid stable while rsp_valid=1 and rsp_ready=0.
REQ-017 SHALL return the pre-write row value (read-before-write) on a same-cycle write and accept to the same row.
REQ-018 SHALL NOT alter a response already held in rsp_data through any later write.
REQ-019 SHALL ignore req_addr and bias_bypass in cycles without accept.
REQ-020 SHALL keep addr_err at 1 once set, until reset.
REQ-021 SHALL have no combinational path from req_valid or req_addr to rsp_data or rsp_valid.

Reset
REQ-022 SHALL, on rst_n=0, immediately clear rsp_valid=0, rsp_data=0, addr_err=0 and every array entry to 0, independent of clk.
REQ-023 SHALL accept no request and perform no write while rst_n=0. req_ready MAY be 1 but is not acted on.
REQ-024 SHALL discard any in-flight response on reset mid-operation, with rsp_valid=0 the cycle after rst_n rises.
REQ-025 SHALL make the first accept possible on the first clk edge with rst_n=1.

Verification
REQ-026 Load rows 0..7, lane j = 16'h0100*row + j, then req_addr=3 with rsp_ready=1. Required: rsp_valid one cycle later, lane 5 = 16'h0305, lane 31 = 16'h031F.
REQ-027 Stream req_addr 0,1,2 on consecutive cycles with rsp_ready=0 on the 2nd response cycle. Required: req_ready=0 during the stall, row-1 data held, no request lost, order 0,1,2.
REQ-028 Same cycle: wr_en to row 2 lane 0 = 16'hBEEF and accept req_addr=2. Required: response lane 0 = 16'h0200; next read of row 2 gives 16'hBEEF.
REQ-029 With DEPTH=6, req_addr=7 and bias_bypass=0. Required: rsp_data all zero, addr_err=1 and staying 1. Repeat with bias_bypass=1 after reset: zeros, addr_err stays 0.
REQ-030 Assert rst_n=0 asynchronously between edges while rsp_valid=1 with a stalled response. Required: rsp_valid, rsp_data and addr_err go to 0 immediately, and a read of row 3 after release returns 0.
